// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 32;
    localparam int FETCH_PC_STEP = 4;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Buffer occupancy at the end of this cycle, given the current flags and this cycle's push/pop.
    function automatic logic [1:0] occ_after(input logic full, input logic empty,
                                             input logic push, input logic pop);
        logic [1:0] base;
        base = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
        return base + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched instructions with their PCs; clear empties it in one cycle.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   clear,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t     slots_r [0:1];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;

    // Storage, pointers and occupancy; clear takes priority over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            slots_r[0] <= '0;
            slots_r[1] <= '0;
        end else if (clear) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                slots_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = slots_r[rd_ptr_r];
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: launches instruction reads at the current PC, buffers returns and feeds decode.
// Defining FETCH_PERF_EN adds saturating perf_stall / perf_flush counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int PC_STEP = FETCH_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               redirect,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_stall,
    output logic [15:0]        perf_flush
`endif
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_r;
    fetch_state_t      state_nxt_s;
    logic              outstanding_r;
    logic              outstanding_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] req_pc_r;

    logic   ack_s;
    logic   pop_s;
    logic   push_s;
    logic   launch_s;
    entry_t push_entry_s;
    entry_t head_s;
    logic   buf_full_s;
    logic   buf_empty_s;

    // Acks without a request in flight (e.g. one that straddled a reset) are ignored.
    assign ack_s        = mem_ack && outstanding_r;
    assign pop_s        = !buf_empty_s && instr_ready && !redirect;
    assign push_entry_s = '{pc: req_pc_r, instr: mem_rdata};

    // Next state, outstanding flag, launch decision and next PC.
    always_comb begin
        state_nxt_s       = state_r;
        outstanding_nxt_s = outstanding_r;
        push_s            = 1'b0;
        launch_s          = 1'b0;
        case (state_r)
            F_IDLE: begin
                state_nxt_s = F_FETCH;
            end
            F_FETCH: begin
                if (redirect) begin
                    if (outstanding_r && !ack_s) begin
                        state_nxt_s = F_FLUSH;
                    end else begin
                        outstanding_nxt_s = 1'b0;
                    end
                end else begin
                    push_s   = ack_s;
                    launch_s = (!outstanding_r || ack_s) &&
                               (occ_after(buf_full_s, buf_empty_s, ack_s, pop_s) < 2'd2);
                    if (launch_s) begin
                        outstanding_nxt_s = 1'b1;
                    end else if (ack_s) begin
                        outstanding_nxt_s = 1'b0;
                    end else begin
                        outstanding_nxt_s = outstanding_r;
                    end
                end
            end
            F_FLUSH: begin
                // The abandoned request's data is dropped when it finally returns.
                if (ack_s) begin
                    state_nxt_s       = F_FETCH;
                    outstanding_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = F_FLUSH;
                end
            end
            default: begin
                state_nxt_s       = F_IDLE;
                outstanding_nxt_s = 1'b0;
            end
        endcase
        next_pc = launch_s ? pc + STEP : pc;
    end

    // State, outstanding flag and request address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= F_IDLE;
            outstanding_r <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            req_pc_r      <= {ADDR_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            if (launch_s) begin
                mem_addr_r <= pc;
                req_pc_r   <= pc;
            end
        end
    end

    fetch_buf #(
        .entry_t (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .clear     (redirect),
        .head      (head_s),
        .full      (buf_full_s),
        .empty     (buf_empty_s)
    );

    assign mem_req     = outstanding_r;
    assign mem_addr    = mem_addr_r;
    assign instr_valid = !buf_empty_s;
    assign instr       = buf_empty_s ? {INSTR_W{1'b0}} : head_s.instr;
    assign instr_pc    = buf_empty_s ? {ADDR_W{1'b0}} : head_s.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_r;
    logic [15:0] perf_flush_r;
    logic        stall_s;
    logic        flush_s;

    assign stall_s = (state_r == F_FETCH) && !launch_s && !outstanding_r;
    assign flush_s = redirect && (!buf_empty_s || (outstanding_r && (state_r != F_FLUSH)));

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_r <= 16'd0;
            perf_flush_r <= 16'd0;
        end else begin
            if (stall_s && (perf_stall_r != 16'hFFFF)) begin
                perf_stall_r <= perf_stall_r + 16'd1;
            end
            if (flush_s && (perf_flush_r != 16'hFFFF)) begin
                perf_flush_r <= perf_flush_r + 16'd1;
            end
        end
    end

    assign perf_stall = perf_stall_r;
    assign perf_flush = perf_flush_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic        redirect;
    logic [7:0]  next_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall;
    logic [15:0] perf_flush;
`endif

    logic [7:0]  target;
    logic        late_ack;
    int          lat, age, lat_min, lat_max;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        o_valid, o_req, o_ack, o_redirect, o_ready;
    logic [7:0]  o_pc_in, o_next_pc, o_ipc, o_addr, o_target;
    logic [31:0] o_instr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .redirect    (redirect),
        .next_pc     (next_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    function automatic logic [31:0] mem_data(input logic [7:0] a);
        return {8'hC3 ^ a, a, ~a, a + 8'h5A};
    endfunction

    // One clock: memory answers, outputs are captured, then the PC counter and memory age update.
    task automatic tick();
        mem_ack   = (mem_req && (age >= lat)) || late_ack;
        mem_rdata = mem_ack ? (late_ack ? 32'hDEAD_BEEF : mem_data(mem_addr)) : $urandom();
        #1;
        o_valid = instr_valid; o_req = mem_req; o_ack = mem_ack; o_redirect = redirect;
        o_ready = instr_ready; o_pc_in = pc; o_next_pc = next_pc; o_ipc = instr_pc;
        o_addr = mem_addr; o_instr = instr; o_target = target;
        @(posedge clk);
        #1;
        if (o_ack) begin
            age = 0;
            lat = $urandom_range(lat_max, lat_min);
        end else if (o_req) begin
            age++;
        end
        pc       = o_redirect ? o_target : o_next_pc;
        redirect = 1'b0;
        late_ack = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] start_pc, input int first_lat);
        rst = 1'b1; redirect = 1'b0; late_ack = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; pc = start_pc; age = 0; lat = first_lat;
    endtask

    task automatic test_reset();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
        n_checks++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 00", instr_pc); end
        lat_min = 0; lat_max = 0;
        rst = 1'b0; pc = 8'h08; age = 0; lat = 0; instr_ready = 1'b1;
        tick();
        n_checks++; if (o_next_pc !== 8'h08 || o_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_launch: got next_pc=%h req=%b expected 08/0", o_next_pc, o_req); end
        tick();
        n_checks++; if (o_next_pc !== 8'h0C) begin n_fail++; $display("FAIL first_launch: got %h expected 0c", o_next_pc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_pc;
        lat_min = 0; lat_max = 0;
        do_reset(8'h10, 0);
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_pc = 8'h10 + 8'(4 * i);
            n_checks++; if (o_pc_in !== exp_pc || o_next_pc !== exp_pc + 8'd4) begin n_fail++; $display("FAIL b2b_next_pc[%0d]: got pc=%h next=%h expected pc=%h next=pc+4", i, o_pc_in, o_next_pc, exp_pc); end
            n_checks++; if (o_valid !== (i >= 2)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, o_valid, (i >= 2)); end
            if (i >= 2) begin
                exp_pc = 8'h10 + 8'(4 * (i - 2));
                n_checks++; if (o_ipc !== exp_pc || o_instr !== mem_data(exp_pc)) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h/%h expected %h/%h", i, o_ipc, o_instr, exp_pc, mem_data(exp_pc)); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_pc;
        lat_min = 0; lat_max = 0;
        do_reset(8'h20, 0);
        instr_ready = 1'b0;
        tick();
        repeat (4) tick();
        n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b expected 0", o_req); end
        n_checks++; if (o_next_pc !== o_pc_in || o_pc_in !== 8'h28) begin n_fail++; $display("FAIL stall_pc_hold: got pc=%h next=%h expected 28/28", o_pc_in, o_next_pc); end
        n_checks++; if (o_valid !== 1'b1 || o_ipc !== 8'h20) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h expected 1/20", o_valid, o_ipc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_pc = 8'h20 + 8'(4 * i);
            n_checks++; if (o_valid !== 1'b1 || o_ipc !== exp_pc || o_instr !== mem_data(exp_pc)) begin n_fail++; $display("FAIL stall_release[%0d]: got v=%b %h/%h expected %h/%h", i, o_valid, o_ipc, o_instr, exp_pc, mem_data(exp_pc)); end
        end
    endtask

    task automatic test_redirect_flush();
        bit found;
        lat_min = 0; lat_max = 0;
        do_reset(8'h30, 2);
        instr_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (o_next_pc !== 8'h34) begin n_fail++; $display("FAIL flush_launch: got %h expected 34", o_next_pc); end
        redirect = 1'b1; target = 8'h94;
        tick();
        n_checks++; if (o_ack !== 1'b0 || o_next_pc !== o_pc_in) begin n_fail++; $display("FAIL flush_redirect_cycle: got ack=%b next=%h expected 0/%h", o_ack, o_next_pc, o_pc_in); end
        tick();
        n_checks++; if (o_req !== 1'b1 || o_addr !== 8'h30 || o_next_pc !== 8'h94) begin n_fail++; $display("FAIL flush_hold: got req=%b addr=%h next=%h expected 1/30/94", o_req, o_addr, o_next_pc); end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (o_valid) begin
                found = 1'b1;
                n_checks++; if (o_ipc !== 8'h94 || o_instr !== mem_data(8'h94)) begin n_fail++; $display("FAIL flush_first: got %h/%h expected 94/%h", o_ipc, o_instr, mem_data(8'h94)); end
            end
        end
        if (!found) begin n_checks++; n_fail++; $display("FAIL flush_timeout: got no instruction expected 94"); end
    endtask

    task automatic test_redirect_ack();
        bit found;
        lat_min = 1; lat_max = 1;
        do_reset(8'h40, 0);
        instr_ready = 1'b0;
        repeat (4) tick();
        lat_min = 0; lat_max = 0;
        redirect = 1'b1; target = 8'h80; instr_ready = 1'b1;
        tick();
        n_checks++; if (o_ack !== 1'b1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rack_setup: got ack=%b valid=%b expected 1/1", o_ack, o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b0 || o_req !== 1'b0) begin n_fail++; $display("FAIL rack_cleared: got valid=%b req=%b expected 0/0", o_valid, o_req); end
        n_checks++; if (o_pc_in !== 8'h80 || o_next_pc !== 8'h84) begin n_fail++; $display("FAIL rack_resume: got pc=%h next=%h expected 80/84", o_pc_in, o_next_pc); end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (o_valid) begin
                found = 1'b1;
                n_checks++; if (o_ipc !== 8'h80 || o_instr !== mem_data(8'h80)) begin n_fail++; $display("FAIL rack_first: got %h/%h expected 80/%h", o_ipc, o_instr, mem_data(8'h80)); end
            end
        end
        if (!found) begin n_checks++; n_fail++; $display("FAIL rack_timeout: got no instruction expected 80"); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        int got;
        lat_min = 0; lat_max = 0;
        do_reset(8'hFC, 0);
        instr_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (o_next_pc !== 8'h00) begin n_fail++; $display("FAIL wrap_next_pc: got %h expected 00", o_next_pc); end
        exp_pc = 8'hFC; got = 0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            tick();
            if (o_valid) begin
                n_checks++; if (o_ipc !== exp_pc || o_instr !== mem_data(exp_pc)) begin n_fail++; $display("FAIL wrap_instr: got %h/%h expected %h/%h", o_ipc, o_instr, exp_pc, mem_data(exp_pc)); end
                exp_pc = exp_pc + 8'd4; got++;
            end
        end
        if (got < 2) begin n_checks++; n_fail++; $display("FAIL wrap_timeout: got %0d instructions expected 2", got); end
    endtask

    task automatic test_reset_mid();
        bit found;
        lat_min = 3; lat_max = 3;
        do_reset(8'h50, 3);
        instr_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL midrst_mem: got req=%b addr=%h expected 0/00", mem_req, mem_addr); end
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h00) begin n_fail++; $display("FAIL midrst_instr: got v=%b %h/%h expected 0/0/0", instr_valid, instr, instr_pc); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; pc = 8'h60; age = 0; lat = 0; lat_min = 0; lat_max = 0;
        late_ack = 1'b1;
        tick();
        late_ack = 1'b1;
        tick();
        n_checks++; if (o_next_pc !== 8'h64) begin n_fail++; $display("FAIL midrst_restart: got %h expected 64", o_next_pc); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (o_valid) begin
                found = 1'b1;
                n_checks++; if (o_ipc !== 8'h60 || o_instr !== mem_data(8'h60)) begin n_fail++; $display("FAIL midrst_first: got %h/%h expected 60/%h", o_ipc, o_instr, mem_data(8'h60)); end
            end
        end
        if (!found) begin n_checks++; n_fail++; $display("FAIL midrst_timeout: got no instruction expected 60"); end
    endtask

    // Random traffic: decode must see consecutive PCs from the last redirect target, each with its memory word.
    task automatic test_random();
        logic [7:0] exp_pc, prev_pc_in, prev_addr;
        logic       prev_launch, prev_req, prev_ack, prev_redirect, launched;
        int         delivered;
        lat_min = 0; lat_max = 3;
        do_reset(8'h84, 1);
        exp_pc = 8'h84; prev_pc_in = 8'h00; prev_addr = 8'h00;
        prev_launch = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_redirect = 1'b0;
        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            instr_ready = ($urandom_range(9, 0) < 7);
            if (i > 1 && $urandom_range(19, 0) == 0) begin
                redirect = 1'b1;
                target   = 8'($urandom()) & 8'hFC;
            end
            tick();
            launched = (o_next_pc !== o_pc_in);
            n_checks++; if (launched && o_next_pc !== o_pc_in + 8'd4) begin n_fail++; $display("FAIL rnd_next_pc[%0d]: got %h expected %h or %h", i, o_next_pc, o_pc_in, o_pc_in + 8'd4); end
            if (o_redirect) begin
                n_checks++; if (launched) begin n_fail++; $display("FAIL rnd_redirect_launch[%0d]: got next=%h expected %h", i, o_next_pc, o_pc_in); end
            end
            if (prev_redirect) begin
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_after_redirect[%0d]: got valid=%b expected 0", i, o_valid); end
            end
            if (prev_launch) begin
                n_checks++; if (o_req !== 1'b1 || o_addr !== prev_pc_in) begin n_fail++; $display("FAIL rnd_req_addr[%0d]: got req=%b addr=%h expected 1/%h", i, o_req, o_addr, prev_pc_in); end
            end else if (prev_req && !prev_ack) begin
                n_checks++; if (o_req !== 1'b1 || o_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_hold[%0d]: got req=%b addr=%h expected 1/%h", i, o_req, o_addr, prev_addr); end
            end
            if (o_valid && o_ready && !o_redirect) begin
                n_checks++; if (o_ipc !== exp_pc || o_instr !== mem_data(exp_pc)) begin n_fail++; $display("FAIL rnd_deliver[%0d]: got %h/%h expected %h/%h", i, o_ipc, o_instr, exp_pc, mem_data(exp_pc)); end
                exp_pc = exp_pc + 8'd4;
                delivered++;
            end
            if (o_redirect) exp_pc = o_target;
            prev_launch = launched; prev_pc_in = o_pc_in; prev_req = o_req;
            prev_ack = o_ack; prev_addr = o_addr; prev_redirect = o_redirect;
        end
        n_checks++; if (delivered < 60) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries expected at least 60", delivered); end
    endtask

    initial begin
        rst = 1'b1; pc = 8'h00; redirect = 1'b0; target = 8'h00; mem_ack = 1'b0;
        mem_rdata = 32'h0; instr_ready = 1'b0; late_ack = 1'b0;
        lat = 0; age = 0; lat_min = 0; lat_max = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_flush();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
